fifo_stream_reader: RTL and testbench
=====================================

# fifo_stream_reader

Downstream drain stage for the synchronous FIFO. It pops words from the FIFO read port, absorbs the FIFO's one-cycle registered read latency in a 2-entry output buffer, and presents the words on a valid/ready stream at full throughput. It also converts FIFO underflow reports into a sticky error flag.

## Interface
- DATA_WIDTH, 16, width of FIFO data and stream data
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- drain_en  in  1  when 0, no new FIFO reads are issued; in-flight and buffered words still drain
- fifo_data_out  in  DATA_WIDTH  FIFO read data, valid the cycle after fifo_rd_en
- fifo_empty  in  1  FIFO empty flag, registered in the FIFO
- fifo_underflow  in  1  FIFO underflow flag, valid the cycle after fifo_rd_en
- fifo_rd_en  out  1  FIFO read request, combinational
- m_data  out  DATA_WIDTH  stream data, head of the buffer
- m_valid  out  1  stream valid
- m_ready  in  1  stream ready from the consumer
- err_underflow  out  1  sticky underflow error; cleared only by reset

## Operation
- State: `count` (0..2, buffered words), `inflight` (1 bit, a read was issued last cycle), 2-entry buffer with head/tail pointers.
- pop = m_valid && m_ready.
- fifo_rd_en = drain_en && !fifo_empty && (count + inflight - pop) < 2. This is the only combinational path from m_ready.
- inflight <= fifo_rd_en every cycle.
- Capture: if inflight && !fifo_underflow, write fifo_data_out at tail, advance tail. If inflight && fifo_underflow, discard the word and set err_underflow.
- Pop: on pop, advance head.
- count <= count + capture - pop. Simultaneous capture and pop are legal, and count is unchanged.
- m_valid = (count != 0). m_data = buffer[head]. Both come from registers.
- Pointers are 1 bit and wrap naturally.
- Stream rule: once m_valid is asserted, m_data holds stable until pop.
- Overflow of the buffer is impossible by construction. An assertion must check that count never exceeds 2.

## Timing
- Reset values: fifo_rd_en=0 (count=0, inflight=0), m_valid=0, m_data=0, err_underflow=0, pointers=0, and all buffer entries are 0.
- Latency: fifo_rd_en high in cycle t → data on fifo_data_out in cycle t+1 → captured at the end of t+1 → m_valid=1 in cycle t+2.
- Throughput: with m_ready held at 1 and the FIFO non-empty, fifo_rd_en is high every cycle and m_valid is high every cycle after the 2-cycle fill.
- Backpressure: with m_ready=0, at most 2 words are buffered. fifo_rd_en drops once count + inflight reaches 2.
- drain_en falling mid-stream: the in-flight word is still captured and no new read is issued.
- Reset mid-operation: all state is cleared immediately and in-flight data is lost.

## Configuration
- FIFO_READER_STATS_EN is the only build-time option.
- Defined: adds output `pop_count` (16 bits, increments on each pop, wraps 0xFFFF→0) and output `underflow_count` (8 bits, increments on each discarded underflow, saturates at 0xFF). Both reset to 0.
- Undefined: these ports and counters are absent, and behaviour is otherwise identical.

## Structure
- shared_pkg holds:
  - the DATA_WIDTH default constant;
  - READER_BUF_DEPTH=2;
  - the stats counter widths (16 and 8).
- Sub-module fifo_reader_skid holds the 2-entry buffer, its pointers and `count`. It has ports wr/wr_data/rd/rd_data/count.
- The top level holds the issue logic, `inflight`, the underflow handling and the stats counters.

## Test plan
- Reset, FIFO preloaded with 0x0001..0x0004, m_ready=1, drain_en=1 → fifo_rd_en high for 4 consecutive cycles; m_data 0x0001..0x0004 on 4 consecutive cycles starting 2 cycles after the first read; then m_valid=0.
- FIFO holding 8 words, m_ready=0 → exactly 2 reads issued; m_valid=1 with m_data stable at the first word. Raise m_ready → remaining 6 words stream back-to-back in order.
- m_ready toggling 1,0,1,0 over 16 words → no word lost or duplicated; count never exceeds 2 (assertion).
- fifo_underflow forced high in the cycle after a read → word discarded; err_underflow=1 and stays high; underflow_count=1 with FIFO_READER_STATS_EN defined.
- drain_en dropped in the same cycle a read is in flight → that word still appears on m_data and no further fifo_rd_en occurs.
- rst_n asserted while count=2 → m_valid, fifo_rd_en and err_underflow are 0 immediately (asynchronous), and pop_count=0.

Source files
------------

// File: rtl/shared_pkg.sv
// Shared constants for the FIFO stream reader: data width default, skid
// buffer depth and statistics counter widths.
package shared_pkg;

    localparam int DATA_WIDTH_DEF   = 16;
    localparam int READER_BUF_DEPTH = 2;
    localparam int POP_COUNT_W      = 16;
    localparam int UF_COUNT_W       = 8;

    typedef logic [1:0] buf_count_t;

endpackage

// File: rtl/fifo_reader_skid.sv
// Two-entry output buffer for the FIFO stream reader; holds the words that
// arrive from the FIFO read latency until the stream consumer takes them.
module fifo_reader_skid
    import shared_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] rd_data,
    output buf_count_t            count
);

    logic [DATA_WIDTH-1:0] r_mem [READER_BUF_DEPTH];
    logic                  r_head;
    logic                  r_tail;
    buf_count_t            r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < READER_BUF_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
            r_count <= '0;
        end else begin
            if (wr) begin
                r_mem[r_tail] <= wr_data;
                r_tail        <= ~r_tail;
            end
            if (rd) begin
                r_head <= ~r_head;
            end
            r_count <= r_count + buf_count_t'(wr) - buf_count_t'(rd);
        end
    end

    assign rd_data = r_mem[r_head];
    assign count   = r_count;

    // The issue logic upstream guarantees the buffer can never overfill.
    a_count_max: assert property (@(posedge clk) disable iff (!rst_n)
        r_count <= buf_count_t'(READER_BUF_DEPTH));
    a_no_overfill: assert property (@(posedge clk) disable iff (!rst_n)
        (wr && !rd) |-> (r_count < buf_count_t'(READER_BUF_DEPTH)));

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a synchronous FIFO onto a valid/ready stream at full throughput.
// Optional build macro FIFO_READER_STATS_EN adds pop and underflow counters.
module fifo_stream_reader
    import shared_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   drain_en,
    input  logic [DATA_WIDTH-1:0]  fifo_data_out,
    input  logic                   fifo_empty,
    input  logic                   fifo_underflow,
    output logic                   fifo_rd_en,
    output logic [DATA_WIDTH-1:0]  m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic                   err_underflow
`ifdef FIFO_READER_STATS_EN
    ,
    output logic [POP_COUNT_W-1:0] pop_count,
    output logic [UF_COUNT_W-1:0]  underflow_count
`endif
);

    logic       r_inflight;
    logic       r_err;
    buf_count_t w_count;
    logic       w_pop;
    logic       w_capture;
    logic       w_discard;
    logic [2:0] w_occupancy;

    assign m_valid   = (w_count != '0);
    assign w_pop     = m_valid && m_ready;
    assign w_capture = r_inflight && !fifo_underflow;
    assign w_discard = r_inflight && fifo_underflow;

    // Slots already committed once this cycle's pop is accounted for.
    assign w_occupancy = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};

    // Gated by rst_n so no read request leaks out while reset is held.
    assign fifo_rd_en = rst_n && drain_en && !fifo_empty &&
                        (w_occupancy < 3'(READER_BUF_DEPTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_inflight <= fifo_rd_en;
            if (w_discard) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err_underflow = r_err;

    fifo_reader_skid #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr      (w_capture),
        .wr_data (fifo_data_out),
        .rd      (w_pop),
        .rd_data (m_data),
        .count   (w_count)
    );

`ifdef FIFO_READER_STATS_EN
    logic [POP_COUNT_W-1:0] r_pop_count;
    logic [UF_COUNT_W-1:0]  r_uf_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pop_count <= '0;
            r_uf_count  <= '0;
        end else begin
            if (w_pop) begin
                r_pop_count <= r_pop_count + 1'b1;
            end
            if (w_discard && (r_uf_count != '1)) begin
                r_uf_count <= r_uf_count + 1'b1;
            end
        end
    end

    assign pop_count       = r_pop_count;
    assign underflow_count = r_uf_count;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a small behavioural FIFO model.
// Stats checks are compiled in when FIFO_READER_STATS_EN is defined.
module tb_fifo_stream_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        drain_en = 1'b0;
    logic [15:0] fifo_data_out;
    logic        fifo_empty;
    logic        fifo_underflow;
    logic        fifo_rd_en;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic        err_underflow;
`ifdef FIFO_READER_STATS_EN
    logic [15:0] pop_count;
    logic [7:0]  underflow_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural FIFO: registered read data and underflow, empty from pointers.
    logic [15:0] fmem [32];
    int unsigned frd = 0;
    int unsigned fwr = 0;
    logic [15:0] fdout = '0;
    logic        fuf = 1'b0;
    logic        force_uf = 1'b0;

    assign fifo_empty     = (frd == fwr);
    assign fifo_data_out  = fdout;
    assign fifo_underflow = fuf | force_uf;

    always @(posedge clk) begin
        if (fifo_rd_en && !fifo_empty) begin
            fdout <= fmem[frd % 32];
            frd   <= frd + 1;
        end
        fuf <= fifo_rd_en && fifo_empty;
    end

    always #5 clk = ~clk;

    fifo_stream_reader dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .drain_en       (drain_en),
        .fifo_data_out  (fifo_data_out),
        .fifo_empty     (fifo_empty),
        .fifo_underflow (fifo_underflow),
        .fifo_rd_en     (fifo_rd_en),
        .m_data         (m_data),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .err_underflow  (err_underflow)
`ifdef FIFO_READER_STATS_EN
        ,
        .pop_count       (pop_count),
        .underflow_count (underflow_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [15:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            fmem[fwr % 32] = base + 16'(i);
            fwr++;
        end
    endtask

    task automatic apply_reset();
        rst_n    = 1'b0;
        drain_en = 1'b0;
        m_ready  = 1'b0;
        force_uf = 1'b0;
        fwr      = frd;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int          nreads;
        int          got;
        logic        hold;
        logic [15:0] held;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_err", err_underflow, 0);
        check("rst_rd_en", fifo_rd_en, 0);
`ifdef FIFO_READER_STATS_EN
        check("rst_pop_count", pop_count, 0);
        check("rst_uf_count", underflow_count, 0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // Full-throughput drain of 4 words
        preload(16'h0001, 4);
        drain_en = 1'b1;
        m_ready  = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            check($sformatf("t1_rd_en_c%0d", k), fifo_rd_en, (k < 4));
            check($sformatf("t1_valid_c%0d", k), m_valid, (k >= 2 && k < 6));
            if (k >= 2 && k < 6) begin
                check($sformatf("t1_data_c%0d", k), m_data, k - 1);
                $display("[TB] t1 word 0x%04h", m_data);
            end
            @(negedge clk);
        end

        // Backpressure: only two reads while m_ready is low
        apply_reset();
        preload(16'h0010, 8);
        drain_en = 1'b1;
        m_ready  = 1'b0;
        nreads   = 0;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (fifo_rd_en) nreads++;
            @(negedge clk);
        end
        #1;
        check("t2_reads", nreads, 2);
        check("t2_valid", m_valid, 1);
        check("t2_data_hold", m_data, 16'h0010);
        @(negedge clk);
        m_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            #1;
            check($sformatf("t2_valid_c%0d", k), m_valid, (k < 8));
            if (k < 8) begin
                check($sformatf("t2_data_c%0d", k), m_data, 16'h0010 + k);
                $display("[TB] t2 word 0x%04h", m_data);
            end
            @(negedge clk);
        end

        // m_ready toggling over 16 words
        apply_reset();
        preload(16'h0100, 16);
        drain_en = 1'b1;
        got  = 0;
        hold = 1'b0;
        held = '0;
        for (int cyc = 0; cyc < 100 && got < 16; cyc++) begin
            m_ready = ~cyc[0];
            #1;
            if (hold) begin
                check("t3_stable_valid", m_valid, 1);
                check("t3_stable_data", m_data, held);
            end
            hold = m_valid && !m_ready;
            held = m_data;
            if (m_valid && m_ready) begin
                check($sformatf("t3_word%0d", got), m_data, 16'h0100 + got);
                $display("[TB] t3 word %0d data 0x%04h", got, m_data);
                got++;
            end
            @(negedge clk);
        end
        check("t3_count", got, 16);
        repeat (3) @(negedge clk);
        #1;
        check("t3_drained", m_valid, 0);

        // drain_en dropped while a read is in flight
        apply_reset();
        preload(16'h0021, 3);
        drain_en = 1'b1;
        m_ready  = 1'b1;
        #1;
        check("t5_rd_first", fifo_rd_en, 1);
        @(negedge clk);
        drain_en = 1'b0;
        #1;
        check("t5_rd_c1", fifo_rd_en, 0);
        check("t5_valid_c1", m_valid, 0);
        @(negedge clk);
        #1;
        check("t5_valid_c2", m_valid, 1);
        check("t5_data_c2", m_data, 16'h0021);
        check("t5_rd_c2", fifo_rd_en, 0);
        @(negedge clk);
        #1;
        check("t5_valid_c3", m_valid, 0);
        check("t5_rd_c3", fifo_rd_en, 0);

        // Underflow reported for an issued read
        apply_reset();
        preload(16'h0055, 1);
        drain_en = 1'b1;
        m_ready  = 1'b1;
        #1;
        check("t4_rd", fifo_rd_en, 1);
        @(negedge clk);
        force_uf = 1'b1;
        #1;
        check("t4_err_before", err_underflow, 0);
        @(negedge clk);
        force_uf = 1'b0;
        #1;
        check("t4_err", err_underflow, 1);
        check("t4_discard", m_valid, 0);
        repeat (2) @(negedge clk);
        #1;
        check("t4_err_sticky", err_underflow, 1);
        check("t4_no_word", m_valid, 0);
`ifdef FIFO_READER_STATS_EN
        check("t4_uf_count", underflow_count, 1);
`endif

        // Async reset while the buffer holds two words
        @(negedge clk);
        m_ready = 1'b1;
        preload(16'h0031, 4);
        repeat (4) @(negedge clk);
        m_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("t6_valid_pre", m_valid, 1);
        check("t6_data_pre", m_data, 16'h0033);
        check("t6_err_pre", err_underflow, 1);
`ifdef FIFO_READER_STATS_EN
        check("t6_pop_pre", pop_count, 2);
`endif
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_valid_rst", m_valid, 0);
        check("t6_rd_rst", fifo_rd_en, 0);
        check("t6_err_rst", err_underflow, 0);
        check("t6_data_rst", m_data, 0);
`ifdef FIFO_READER_STATS_EN
        check("t6_pop_rst", pop_count, 0);
        check("t6_uf_rst", underflow_count, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
